instruction_fetch: RTL and testbench

Fetch stage between the program counter and the decoder. Owns the 64-bit PC and drives the byte address into the synchronous instruction memory, which returns the 32-bit little-endian word one clock later. Pairs each returned word with its PC and hands the pair to the decoder over a valid/ready handshake, with a two-entry buffer for decoder stalls. Accepts branch redirects (CBZ/B targets resolved downstream), flushing every wrong-path word.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buffer.sv | 67 ++++++
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and FSM states for the instruction fetch stage.
// HALT is present only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef FETCH_ALIGN_CHECK_EN
    , HALT
`endif
  } state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: output register plus one skid entry, strict order, flushable.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic [ADDR_W-1:0]  in_pc_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic               skid_valid_o
);
  logic               out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic               free;
  assign free = !out_valid_q || out_ready_i;
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (free) begin
      // the skid entry is older than the incoming word, so it goes out first
      out_valid_d  = skid_valid_q || in_valid_i;
      out_instr_d  = skid_valid_q ? skid_instr_q : in_valid_i ? in_instr_i : out_instr_q;
      out_pc_d     = skid_valid_q ? skid_pc_q : in_valid_i ? in_pc_i : out_pc_q;
      skid_valid_d = skid_valid_q && in_valid_i;
      skid_instr_d = in_instr_i;
      skid_pc_d    = in_pc_i;
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr_i;
      skid_pc_d    = in_pc_i;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
  assign out_valid_o  = out_valid_q;
  assign out_instr_o  = out_instr_q;
  assign out_pc_o     = out_pc_q;
  assign skid_valid_o = skid_valid_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, fetch FSM and inflight tracking feeding a two-entry output buffer.
// FETCH_ALIGN_CHECK_EN adds the fault port and the HALT state for misaligned redirects.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               done
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic             fault
`endif
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - PC_STEP);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, infl_pc_q, infl_pc_d, target;
  logic              infl_valid_q, infl_valid_d, done_q, done_d;
  logic              skid_valid, drain, issue, redir;
  logic [1:0]        occ_after;
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d, misaligned;
  assign target     = redirect_target;
  assign misaligned = |redirect_target[1:0];
  assign redir      = redirect_valid && state_q != HALT;
  assign fault      = fault_q;
`else
  assign target = redirect_target & ~ADDR_W'(3);
  assign redir  = redirect_valid;
`endif
  assign drain     = out_valid && out_ready;
  assign occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(infl_valid_q) - 2'(drain);
  assign issue     = state_q == RUN && !redirect_valid && pc_q <= LAST_PC && occ_after < 2'd2;
  assign fetch_addr = pc_q;
  assign done       = done_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = issue ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    infl_valid_d = issue;
    infl_pc_d    = issue ? pc_q : infl_pc_q;
    done_d       = done_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d      = fault_q;
`endif
    if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
      state_d = misaligned ? HALT : RUN;
      fault_d = fault_q || misaligned;
      pc_d    = misaligned ? pc_q : target;
`else
      state_d = RUN;
      pc_d    = target;
`endif
      done_d  = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (state_q == RUN && pc_q > LAST_PC) begin
      state_d = DONE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
      done_q       <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      done_q       <= done_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= fault_d;
`endif
    end
  end
  // the word returning during a redirect cycle is wrong-path; flush drops it with the rest
  fetch_skid_buffer u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redir),
    .in_valid_i   (infl_valid_q),
    .in_instr_i   (imem_instr),
    .in_pc_i      (infl_pc_q),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_instr_o  (out_instr),
    .out_pc_o     (out_pc),
    .skid_valid_o (skid_valid)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test-plan checks plus a randomized scoreboard on the delivered stream.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int          MEM_BYTES = 4096;
  localparam logic [63:0] LAST      = 64'(MEM_BYTES - 4);
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mem [0:1023];
  logic [63:0] fa0, opc0, rt0, fa1, opc1, rt1;
  logic [31:0] im0, oi0, im1, oi1;
  logic        ov0, ord0, rv0, dn0, ov1, ord1, rv1, dn1;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        flt0, flt1;
`endif
  int          passed = 0, total = 0;
  logic [63:0] expq[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] rd(input logic [63:0] a);
    return (a <= LAST) ? mem[a[11:2]] : 32'h0;
  endfunction
  always @(posedge clk) begin
    im0 <= rd(fa0);
    im1 <= rd(fa1);
  end
  instruction_fetch #(.RESET_PC(64'd0), .MEM_BYTES(MEM_BYTES)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_addr(fa0), .imem_instr(im0),
    .out_valid(ov0), .out_ready(ord0), .out_instr(oi0), .out_pc(opc0),
    .redirect_valid(rv0), .redirect_target(rt0), .done(dn0)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fault(flt0)
`endif
  );
  instruction_fetch #(.RESET_PC(64'd4088), .MEM_BYTES(MEM_BYTES)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_addr(fa1), .imem_instr(im1),
    .out_valid(ov1), .out_ready(ord1), .out_instr(oi1), .out_pc(opc1),
    .redirect_valid(rv1), .redirect_target(rt1), .done(dn1)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fault(flt1)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // expected stream: sequential words from a start address up to the last fetchable one
  function automatic void load(input logic [63:0] s);
    expq.delete();
    for (logic [63:0] a = s; a <= LAST; a += 64'd4) expq.push_back(a);
  endfunction
  always @(negedge clk) begin
    if (!rst_n) load(64'd0);
    else begin
      if (ov0 && ord0) begin
        if (expq.size() == 0) begin
          total++;
          $display("FAIL sb_extra: pc %0h delivered, none expected", opc0);
        end else begin
          logic [63:0] e;
          e = expq.pop_front();
          chk("sb_pc", opc0, e);
          chk("sb_instr", {32'h0, oi0}, {32'h0, rd(e)});
        end
      end
      if (rv0) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (rt0[1:0] != 2'b00) expq.delete();
        else load(rt0);
`else
        load(rt0 & ~64'h3);
`endif
      end
    end
  end
  initial begin
    ord0 = 1'b1; ord1 = 1'b1; rv0 = 1'b0; rt0 = '0; rv1 = 1'b0; rt1 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'hAB020020; mem[1] = 32'hB1002020; mem[2] = 32'hEB020020;
    mem[3] = 32'hF1002020; mem[4] = 32'h8A020020; mem[9] = 32'hB4000041;
    repeat (2) step();
    chk("rst_valid", 64'(ov0), 0); chk("rst_pc", opc0, 0); chk("rst_instr", 64'(oi0), 0);
    chk("rst_done", 64'(dn0), 0); chk("rst_addr0", fa0, 0); chk("rst_addr1", fa1, 64'd4088);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", 64'(flt0), 0);
`endif
    rst_n = 1'b1;
    step(); chk("e1_valid", 64'(ov0), 0);
    step(); chk("e2_valid", 64'(ov0), 0); chk("e2_addr", fa0, 4);
    step(); chk("e3_valid", 64'(ov0), 1); chk("e3_pc", opc0, 0); chk("e3_instr", 64'(oi0), 64'hAB020020);
    chk("hi_pc0", opc1, 64'd4088); chk("hi_instr0", 64'(oi1), 64'(mem[1022]));
    step(); chk("e4_pc", opc0, 4); chk("e4_instr", 64'(oi0), 64'hB1002020);
    chk("hi_pc1", opc1, 64'd4092); chk("hi_done", 64'(dn1), 1);
    step(); chk("e5_pc", opc0, 8); chk("e5_instr", 64'(oi0), 64'hEB020020);
    chk("hi_drained", 64'(ov1), 0); chk("hi_no_issue", fa1, 64'd4096);
    ord0 = 1'b0; rv1 = 1'b1; rt1 = 64'd0;
    step(); rv1 = 1'b0; chk("hi_done_clr", 64'(dn1), 0);
    chk("stall1_pc", opc0, 8); chk("stall1_addr", fa0, 16);
    step(); chk("stall2_pc", opc0, 8); chk("stall2_addr", fa0, 16);
    step(); chk("stall3_pc", opc0, 8); chk("stall3_valid", 64'(ov0), 1); chk("hi_resume_pc", opc1, 0);
    ord0 = 1'b1;
    step(); chk("rel_pc12", opc0, 12); chk("rel_instr12", 64'(oi0), 64'hF1002020);
    step(); chk("rel_pc16", opc0, 16); chk("rel_instr16", 64'(oi0), 64'h8A020020);
    ord0 = 1'b0;
    step(); chk("buf2_pc", opc0, 16);
    rv0 = 1'b1; rt0 = 64'h24;
    step(); rv0 = 1'b0; ord0 = 1'b1; chk("redir_flush", 64'(ov0), 0);
    step(); chk("redir_gap", 64'(ov0), 0); chk("redir_issue", fa0, 64'h28);
    step(); chk("redir_valid", 64'(ov0), 1); chk("redir_pc", opc0, 64'h24);
    chk("redir_instr", 64'(oi0), 64'hB4000041);
    for (int c = 0; c < 400; c++) begin
      ord0 = ($urandom % 4) != 0;
      rv0  = ($urandom % 24) == 0;
      rt0  = ($urandom % 2) ? 64'($urandom_range(1000, 1023) * 4) : 64'($urandom_range(0, 1023) * 4);
      step();
    end
    ord0 = 1'b1; rv0 = 1'b1; rt0 = 64'd4080;
    step(); rv0 = 1'b0;
    begin
      int n = 0;
      while (!dn0 && n < 20) begin step(); n++; end
    end
    chk("end_done", 64'(dn0), 1);
    repeat (3) step();
    chk("end_idle", 64'(ov0), 0); chk("end_addr", fa0, 64'd4096); chk("end_all_seen", 64'(expq.size()), 0);
    rv0 = 1'b1; rt0 = 64'd0;
    step(); rv0 = 1'b0; chk("resume_done", 64'(dn0), 0);
    step(); step(); chk("resume_pc", opc0, 0); chk("resume_valid", 64'(ov0), 1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov0), 0); chk("arst_pc", opc0, 0); chk("arst_instr", 64'(oi0), 0);
    chk("arst_addr", fa0, 0);
    step(); rst_n = 1'b1;
    step(); step(); chk("arst_e2_valid", 64'(ov0), 0);
    step(); chk("arst_e3_valid", 64'(ov0), 1); chk("arst_e3_pc", opc0, 0);
    step(); step();
    rv0 = 1'b1; rt0 = 64'h26;
    step(); rv0 = 1'b0; chk("mis_flush", 64'(ov0), 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 64'(flt0), 1);
    for (int c = 0; c < 5; c++) begin step(); chk("mis_halt", 64'(ov0), 0); end
`else
    step(); chk("mis_gap", 64'(ov0), 0);
    step(); chk("mis_pc", opc0, 64'h24); chk("mis_instr", 64'(oi0), 64'hB4000041);
`endif
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
